mips_muldiv_unit: RTL and testbench

Multiply/divide unit with architectural HI/LO registers, fed directly by the register file's two read ports (`src_data_1` -> `operand_a`, `src_data_2` -> `operand_b`). Executes MULT, MULTU, DIV, DIVU with an iterative 32-step datapath, plus single-cycle MTHI/MTLO writes. HI/LO are exposed continuously for MFHI/MFLO. `busy` lets the control stall any dependent instruction.

---
 rtl/mips_muldiv_pkg.sv | 34 +++
 rtl/mips_muldiv_iter.sv | 75 +++++++
 rtl/mips_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the MIPS multiply/divide unit: op codes, FSM state
// encodings, iteration/latency counts and a small operand helper.
// Optional build macro: MIPS_MULDIV_FAST_MULT_EN (single-cycle MULT/MULTU).
package mips_muldiv_pkg;

    localparam int MULDIV_WIDTH       = 32;
    localparam int MULDIV_ITER_CYCLES = 32;
    localparam int MULDIV_LATENCY     = 33;

    // Op codes as presented on op_code; 6 and 7 are reserved and ignored.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // FSM state encodings.
    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t ST_IDLE = 2'd0;
    localparam muldiv_state_t ST_ITER = 2'd1;
    localparam muldiv_state_t ST_FIX  = 2'd2;

    // Magnitude of an operand; only negated when the op is signed and the
    // value is negative. 32'h8000_0000 maps to itself, which is the correct
    // unsigned magnitude.
    function automatic logic [MULDIV_WIDTH-1:0] abs_val(
        input logic [MULDIV_WIDTH-1:0] v,
        input logic                    is_signed
    );
        return (is_signed && v[MULDIV_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// Iterative 64-bit shift datapath: unsigned shift-add multiply and
// restoring shift-subtract divide, one step per cycle, with a step counter.
// Multiply: acc_lo starts as the multiplier, opnd is the multiplicand.
// Divide:   acc_lo starts as the dividend (ends as quotient), opnd is the
//           divisor, acc_hi ends as the remainder.
module mips_muldiv_iter
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_opnd,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    localparam int CNT_W = $clog2(MULDIV_ITER_CYCLES);

    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   mult_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    // One step of either algorithm, selected by is_div.
    always_comb begin
        mult_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (is_div) begin
            next_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            next_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            next_hi = mult_sum[WIDTH:1];
            next_lo = {mult_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Accumulator and counter: load clears, step advances; counter wraps 31 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            acc_hi_q <= '0;
            acc_lo_q <= load_lo;
            opnd_q   <= load_opnd;
            cnt_q    <= '0;
        end else if (step) begin
            acc_hi_q <= next_hi;
            acc_lo_q <= next_lo;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign acc_hi = acc_hi_q;
    assign acc_lo = acc_lo_q;
    assign last   = (cnt_q == CNT_W'(MULDIV_ITER_CYCLES - 1));

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS multiply/divide unit with architectural HI/LO registers.
// FSM IDLE -> ITER (32 steps) -> FIX (sign fix, HI/LO commit, done pulse).
// Optional build macro: MIPS_MULDIV_FAST_MULT_EN makes MULT/MULTU complete
// through a single-cycle multiplier at the start edge; divides stay iterative.
// Handshake: op_start is a one-cycle request sampled on the rising edge; it is
// accepted only while busy=0 and otherwise dropped, so control must stall.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t    state_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             is_div_q;
    logic             res_neg_q;
    logic             rem_neg_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] a_raw_q;

    logic             start_ok;
    logic             iter_start;
    logic             op_signed;
    logic             op_is_div;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             iter_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // Accept a mult/div only from IDLE; requests during busy are dropped.
    assign start_ok  = op_start && (state_q == ST_IDLE) && (op_code <= OP_DIVU);
    assign op_signed = ~op_code[0];
    assign op_is_div = op_code[1];
    assign abs_a     = abs_val(operand_a, op_signed);
    assign abs_b     = abs_val(operand_b, op_signed);

`ifdef MIPS_MULDIV_FAST_MULT_EN
    logic               fast_start;
    logic [2*WIDTH-1:0] fast_prod;

    assign iter_start = start_ok && op_is_div;
    assign fast_start = start_ok && !op_is_div;

    // Single-cycle product; sign- or zero-extend then keep the low 64 bits.
    always_comb begin
        if (op_signed)
            fast_prod = {{WIDTH{operand_a[WIDTH-1]}}, operand_a} *
                        {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
        else
            fast_prod = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};
    end
`else
    assign iter_start = start_ok;
`endif

    mips_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (iter_start),
        .step      (state_q == ST_ITER),
        .is_div    (is_div_q),
        .load_lo   (op_is_div ? abs_a : abs_b),
        .load_opnd (op_is_div ? abs_b : abs_a),
        .acc_hi    (acc_hi),
        .acc_lo    (acc_lo),
        .last      (iter_last)
    );

    // Sign correction of the unsigned magnitude result, plus divide-by-zero.
    always_comb begin
        prod_fix = res_neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            fix_lo = res_neg_q ? -acc_lo : acc_lo;
            fix_hi = rem_neg_q ? -acc_hi : acc_hi;
            if (b_zero_q) begin
                fix_hi = a_raw_q;
                fix_lo = '1;
            end
        end
    end

    // Control FSM and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_raw_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iter_start) begin
                        state_q   <= ST_ITER;
                        is_div_q  <= op_is_div;
                        res_neg_q <= op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        rem_neg_q <= op_signed && operand_a[WIDTH-1];
                        b_zero_q  <= (operand_b == '0);
                        a_raw_q   <= operand_a;
`ifdef MIPS_MULDIV_FAST_MULT_EN
                    end else if (fast_start) begin
                        hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                        lo_q   <= fast_prod[WIDTH-1:0];
                        done_q <= 1'b1;
`endif
                    end else if (op_start && op_code == OP_MTHI) begin
                        hi_q <= operand_a;
                    end else if (op_start && op_code == OP_MTLO) begin
                        lo_q <= operand_a;
                    end
                end
                ST_ITER: begin
                    if (iter_last)
                        state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: reset values, MTHI/MTLO,
// directed vector table, ignored request during busy, random ops against a
// plain-arithmetic reference model, and reset abort mid-operation.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic [2:0]  op_code;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;
    vec_t vecs[10];

    mips_muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .op_code   (op_code),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: {HI, LO} from plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int    sa;
        int    sb;
        int    q;
        int    r;
        longint p;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            OP_MULTU: return {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Cycles after the start edge until done is seen.
    function automatic int exp_latency(input logic [2:0] op);
`ifdef MIPS_MULDIV_FAST_MULT_EN
        if (op <= OP_MULTU) return 1;
`endif
        return MULDIV_LATENCY + 1;
    endfunction

    // Issue one mult/div (inputs driven at negedge) and check the full timing profile.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prev;
        logic [63:0] want;
        int lat;
        int done_at;
        int pulses;
        int busy_bad;
        int hold_bad;
        exp_q.push_back(model(op, a, b));
        prev = {hi, lo};
        lat = exp_latency(op);
        op_start = 1'b1;
        op_code = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        done_at = 0;
        pulses = 0;
        busy_bad = 0;
        hold_bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (done_at == 0) done_at = n;
            end
            if (busy !== (lat > 1 && n < lat)) busy_bad++;
            if (n < lat && {hi, lo} !== prev) hold_bad++;
            if (n == lat && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                chk({tag, " result"}, {hi, lo}, want);
            end
        end
        chk({tag, " done_cycle"}, 64'(done_at), 64'(lat));
        chk({tag, " done_pulses"}, 64'(pulses), 64'd1);
        chk({tag, " busy_profile"}, 64'(busy_bad), 64'd0);
        chk({tag, " hilo_hold"}, 64'(hold_bad), 64'd0);
    endtask

    // MTHI/MTLO: visible the cycle after the sampling edge, no busy/done.
    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        op_start = 1'b1;
        op_code = op;
        operand_a = a;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        @(negedge clk);
        if (op == OP_MTHI) chk("mthi hi", 64'(hi), 64'(a));
        else chk("mtlo lo", 64'(lo), 64'(a));
        chk("mt busy", 64'(busy), 64'd0);
        chk("mt done", 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] want;
        logic [31:0] prev_lo;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int pulses;
        int busy_seen;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
        vecs[4] = '{OP_DIVU,  32'd9,         32'd0,        32'd9,         32'hFFFF_FFFF};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        vecs[7] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[9] = '{OP_MULTU, 32'd0,         32'h1234_5678, 32'h0,        32'h0};

        // Reset
        reset = 1'b1;
        op_start = 1'b0;
        op_code = 3'd0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_mt(OP_MTHI, 32'h1234_5678);
        run_mt(OP_MTLO, 32'd7);
        chk("mtlo keeps hi", 64'(hi), 64'h1234_5678);

        // Reserved op code: no effect
        op_start = 1'b1;
        op_code = 3'd6;
        operand_a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        @(negedge clk);
        chk("reserved op hilo", {hi, lo}, {32'h1234_5678, 32'd7});
        chk("reserved op busy", 64'(busy), 64'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d table", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Request during busy is dropped; operand changes do not disturb a DIV
        prev_lo = lo;
        want = model(OP_DIV, 32'hFFFF_FC18, 32'd7);
        op_start = 1'b1;
        op_code = OP_DIV;
        operand_a = 32'hFFFF_FC18;
        operand_b = 32'd7;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) pulses++;
            if (n == 10) begin
                op_start = 1'b1;
                op_code = OP_MTLO;
                operand_a = 32'd5;
                operand_b = 32'd1;
            end
            if (n == 11) begin
                op_start = 1'b0;
                chk("busy mtlo ignored", 64'(lo), 64'(prev_lo));
            end
            if (n == MULDIV_LATENCY + 1) chk("busy div result", {hi, lo}, want);
        end
        chk("busy div pulses", 64'(pulses), 64'd1);

        // Random ops against the reference model
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        // Reset abort mid-operation
        run_mt(OP_MTHI, 32'hA5A5_A5A5);
`ifdef MIPS_MULDIV_FAST_MULT_EN
        op_code = OP_DIVU;
`else
        op_code = OP_MULT;
`endif
        op_start = 1'b1;
        operand_a = 32'd123;
        operand_b = 32'd456;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        reset = 1'b0;
        busy_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        chk("abort no done", 64'(pulses), 64'd0);
        chk("abort stays idle", 64'(busy_seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
